// File: rtl/wide_add_sequencer.sv
// Multi-precision adder: runs one shared 8-bit word adder over NWORDS limbs, LSB first.
// Optional build macro WIDE_ADD_SUB_EN adds a `sub` input selecting A-B instead of A+B.
module wide_add_sequencer #(
    parameter int unsigned NWORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NWORDS-1:0]   a_in,
    input  logic [8*NWORDS-1:0]   b_in,
    input  logic                  cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NWORDS-1:0]   sum,
    output logic                  cout,
    output logic                  busy
);

    localparam int unsigned W     = 8 * NWORDS;
    localparam int unsigned IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned SEL_W = IDX_W + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic               last_limb;
    logic               accept;
    logic               first_carry;
    logic [SEL_W-1:0]   limb_sel;
    logic [7:0]         limb_a;
    logic [7:0]         limb_b;
    logic [8:0]         add_res;

    assign last_limb = (idx == IDX_W'(NWORDS - 1));
    assign accept    = (state == IDLE) && in_valid;
    assign limb_sel  = {idx, 3'b000};

`ifdef WIDE_ADD_SUB_EN
    logic sub_q;

    // Subtraction is A + ~B + 1, so only the initial carry and the B limb change.
    assign first_carry = sub ? 1'b1 : cin;

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= sub;
        end
    end
`else
    assign first_carry = cin;
`endif

    // Shared word adder fed from the current limb of the latched operands.
    always_comb begin
        limb_a = op_a[limb_sel +: 8];
        limb_b = op_b[limb_sel +: 8];
`ifdef WIDE_ADD_SUB_EN
        if (sub_q) begin
            limb_b = ~op_b[limb_sel +: 8];
        end
`endif
        add_res = 9'(limb_a) + 9'(limb_b) + 9'(carry);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_limb) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture and limb-by-limb result accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            op_a  <= a_in;
            op_b  <= b_in;
            carry <= first_carry;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[limb_sel +: 8] <= add_res[7:0];
            carry              <= add_res[8];
            if (last_limb) begin
                cout <= add_res[8];
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule
